pwm_drive: RTL and testbench
============================

Name: pwm_drive

Overview:
Motor PWM output stage. It sits directly downstream of the PID controller and consumes its pwm_update, pwm_ratio and pwm_direction outputs. It converts the 8-bit high-time ratio into a glitch-free PWM waveform plus a direction pin. New ratio/direction values take effect only on period boundaries, and a PWM-low dead time is inserted on direction reversal. It returns pwm_done to the PID controller.

Parameters:
PRESCALE, 16'd1, clocks per PWM count tick (legal range 1..65535); period = 255*PRESCALE clocks
DEAD_PERIODS, 4'd2, full PWM periods of forced-low output on direction reversal (legal range 1..15)

Ports:
clock  input  1  main clock
reset_n  input  1  synchronous active-low reset
pwm_enable  input  1  level enable; low forces output off and returns to IDLE
pwm_update  input  1  level request; ratio/direction sampled every cycle it is high
pwm_ratio  input  8  requested high time, out of 255
pwm_direction  input  1  requested motor direction
pwm_done  output  1  1-cycle pulse: pending value applied at a period boundary
pwm_out  output  1  registered PWM waveform to the motor driver
dir_out  output  1  registered direction to the motor driver
debug_signals  output  8  {4'b0, dir_out, pend_valid, state[1:0]}

Behaviour:
- One clock. Reset is synchronous and active-low: all registers update only on posedge clock, and reset_n low at a posedge resets the block.
- Reset values: pwm_out=0, dir_out=0, pwm_done=0, state=IDLE, active_ratio=0, pend_valid=0, prescaler=0, cnt=0, dead_cnt=0.
- Prescaler: counts 0..PRESCALE-1. tick=1 when prescaler==PRESCALE-1. With PRESCALE=1, tick=1 every cycle.
- cnt (8b): advances on tick, counts 0..254, then wraps to 0. Boundary = tick && cnt==254.
- pwm_out is registered: pwm_out <= (state==RUN) && (cnt < active_ratio), one clock after cnt.
- Ratio edge cases: ratio 0 gives constant low; ratio 255 gives constant high (cnt never reaches 255); ratio N gives N high ticks per period.
- Shadow capture: if pwm_update=1, then pend_ratio<=pwm_ratio, pend_dir<=pwm_direction, pend_valid<=1 in the same cycle.
- The boundary uses the registered pend_* values. If capture and consume happen in the same cycle, the new capture wins (pend_valid stays 1 with the new data).
- States (2b): IDLE=00, RUN=01, DEAD=10.
- IDLE:
  - Counters held at 0; pwm_out=0; pend_valid cleared.
  - pwm_enable=1 moves to RUN with active_ratio=0; cnt starts at 0 on the next tick.
- RUN, at a boundary with pend_valid:
  - If pend_dir==dir_out: active_ratio<=pend_ratio, pend_valid<=0, pwm_done<=1 for one cycle.
  - If pend_dir!=dir_out: go to DEAD, active_ratio<=0, dead_cnt<=0, no pwm_done.
- RUN, at a boundary without pend_valid: active_ratio is held.
- DEAD:
  - pwm_out forced 0; dead_cnt increments at each boundary.
  - When dead_cnt reaches DEAD_PERIODS-1 at a boundary: dir_out<=pend_dir, active_ratio<=pend_ratio, pend_valid<=0, pwm_done pulse, go to RUN.
  - If pend_dir changes back to dir_out during DEAD, the dead time still completes; this is intentional, not an abort.
  - Updates captured during DEAD overwrite pend_*, and the latest values are applied at exit.
- pwm_enable low in any state: next cycle state=IDLE, pwm_out=0, active_ratio=0, pend_valid=0, counters cleared, dir_out held, no pwm_done.
- pwm_done is never high for two consecutive cycles.
- Reset mid-period or mid-DEAD: all registers take reset values at that edge, and the output goes low the same edge.
- Latency: pwm_update to the first changed pwm_out edge is at most 1 full period + 2 clocks in RUN; on reversal it is (DEAD_PERIODS+1) periods + 2 clocks.

Decomposition:
- Shared motor package: state encodings PWM_IDLE/PWM_RUN/PWM_DEAD, PWM_MAX_CNT=8'd254, debug field offsets.
- One natural sub-module: pwm_prescaler (parameterised tick generator with sync clear). Used here, and reusable by other motor timing blocks.

Test Plan:
- PRESCALE=1, enable=1, update ratio=64 dir=0 for 1 cycle → pwm_done pulse at first boundary; thereafter pwm_out high exactly 64 of every 255 clocks.
- Ratio 0, then 255 → pwm_out constant 0 for a full period, then constant 1 for a full period, with no glitch at the wrap.
- Running at ratio 128 dir=0, update dir=1 ratio=100 → at boundary pwm_out low for exactly 2*255 clocks; dir_out toggles on the same cycle as the pwm_done pulse; then 100/255 duty.
- pwm_update held high continuously (PID ACCEL style) with ratio changing 10→20→30 mid-period → each boundary applies the most recent value, one pwm_done per period, duty never changes mid-period.
- Drop pwm_enable mid-period at ratio 200 → pwm_out 0 on next clock; state=IDLE; re-enable produces no pwm_done until a new update.
- Assert reset_n=0 during DEAD → all outputs at reset values on that edge; debug_signals=8'h00.

Source files
------------

// File: rtl/pwm_drive_pkg.sv
// rtl/pwm_drive_pkg.sv - shared motor PWM encodings and debug field layout
package pwm_drive_pkg;

    typedef enum logic [1:0] {
        PWM_IDLE = 2'b00,
        PWM_RUN  = 2'b01,
        PWM_DEAD = 2'b10
    } pwm_state_t;

    // Last count value of a period; cnt never reaches 255 so ratio 255 is solid high
    localparam logic [7:0] PWM_MAX_CNT = 8'd254;

    localparam int DBG_STATE_LSB = 0;
    localparam int DBG_PEND_BIT  = 2;
    localparam int DBG_DIR_BIT   = 3;

    function automatic logic [7:0] pack_debug(input logic dir, input logic pend, input pwm_state_t st);
        logic [7:0] d;
        d = 8'h00;
        d[DBG_STATE_LSB +: 2] = st;
        d[DBG_PEND_BIT]       = pend;
        d[DBG_DIR_BIT]        = dir;
        return d;
    endfunction

endpackage

// File: rtl/pwm_drive_prescaler.sv
// rtl/pwm_drive_prescaler.sv - parameterised tick generator with synchronous clear
module pwm_prescaler #(
    parameter logic [15:0] PRESCALE = 16'd1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    logic [15:0] count;

    assign tick = (count == PRESCALE - 16'd1);

    // Free-running divider, restarted from zero whenever the owner is idle
    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            count <= 16'd0;
        end else if (tick) begin
            count <= 16'd0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/pwm_drive.sv
// rtl/pwm_drive.sv - motor PWM output stage with boundary-aligned updates and reversal dead time
module pwm_drive
    import pwm_drive_pkg::*;
#(
    parameter logic [15:0] PRESCALE     = 16'd1,
    parameter logic [3:0]  DEAD_PERIODS = 4'd2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pwm_enable,
    input  logic       pwm_update,
    input  logic [7:0] pwm_ratio,
    input  logic       pwm_direction,
    output logic       pwm_done,
    output logic       pwm_out,
    output logic       dir_out,
    output logic [7:0] debug_signals
);

    pwm_state_t state, state_next;
    logic [7:0] cnt;
    logic [7:0] active_ratio;
    logic [7:0] pend_ratio;
    logic       pend_dir;
    logic       pend_valid;
    logic [3:0] dead_cnt;
    logic       tick;
    logic       hold_clear;
    logic       boundary;
    logic       apply_run;
    logic       enter_dead;
    logic       exit_dead;
    logic       pwm_level;

    assign hold_clear = !pwm_enable || (state == PWM_IDLE);
    assign boundary   = tick && (cnt == PWM_MAX_CNT);

    pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (hold_clear),
        .tick    (tick)
    );

    // Period counter 0..254, held at zero while idle or disabled
    always_ff @(posedge clock) begin
        if (!reset_n || hold_clear) begin
            cnt <= 8'd0;
        end else if (tick) begin
            cnt <= (cnt == PWM_MAX_CNT) ? 8'd0 : cnt + 8'd1;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= PWM_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: enable low always wins, otherwise transitions only at boundaries
    always_comb begin
        state_next = state;
        if (!pwm_enable) begin
            state_next = PWM_IDLE;
        end else begin
            case (state)
                PWM_IDLE: state_next = PWM_RUN;
                PWM_RUN:  if (enter_dead) state_next = PWM_DEAD;
                PWM_DEAD: if (exit_dead)  state_next = PWM_RUN;
                default:  state_next = PWM_IDLE;
            endcase
        end
    end

    // Boundary events and the unregistered PWM level
    always_comb begin
        apply_run  = pwm_enable && (state == PWM_RUN) && boundary && pend_valid && (pend_dir == dir_out);
        enter_dead = pwm_enable && (state == PWM_RUN) && boundary && pend_valid && (pend_dir != dir_out);
        exit_dead  = pwm_enable && (state == PWM_DEAD) && boundary && (dead_cnt == DEAD_PERIODS - 4'd1);
        pwm_level  = (state == PWM_RUN) && (cnt < active_ratio);
    end

    // Datapath: shadow capture, boundary application, dead-time counting, outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pwm_out      <= 1'b0;
            dir_out      <= 1'b0;
            pwm_done     <= 1'b0;
            active_ratio <= 8'd0;
            pend_ratio   <= 8'd0;
            pend_dir     <= 1'b0;
            pend_valid   <= 1'b0;
            dead_cnt     <= 4'd0;
        end else if (!pwm_enable) begin
            pwm_out      <= 1'b0;
            pwm_done     <= 1'b0;
            active_ratio <= 8'd0;
            pend_valid   <= 1'b0;
            dead_cnt     <= 4'd0;
        end else begin
            pwm_out  <= pwm_level;
            pwm_done <= apply_run || exit_dead;
            if (state == PWM_IDLE) begin
                active_ratio <= 8'd0;
                pend_valid   <= 1'b0;
                dead_cnt     <= 4'd0;
            end else begin
                if (apply_run) begin
                    active_ratio <= pend_ratio;
                    pend_valid   <= 1'b0;
                end
                if (enter_dead) begin
                    active_ratio <= 8'd0;
                    dead_cnt     <= 4'd0;
                end
                if (state == PWM_DEAD && boundary) begin
                    if (exit_dead) begin
                        dir_out      <= pend_dir;
                        active_ratio <= pend_ratio;
                        pend_valid   <= 1'b0;
                        dead_cnt     <= 4'd0;
                    end else begin
                        dead_cnt <= dead_cnt + 4'd1;
                    end
                end
                // A fresh capture overrides a same-cycle consume
                if (pwm_update) begin
                    pend_ratio <= pwm_ratio;
                    pend_dir   <= pwm_direction;
                    pend_valid <= 1'b1;
                end
            end
        end
    end

    assign debug_signals = pack_debug(dir_out, pend_valid, state);

endmodule

// File: tb/tb_pwm_drive.sv
// tb/tb_pwm_drive.sv - directed scoreboard bench for pwm_drive
module tb_pwm_drive;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       pwm_enable = 1'b0;
    logic       pwm_update = 1'b0;
    logic [7:0] pwm_ratio = 8'd0;
    logic       pwm_direction = 1'b0;
    logic       pwm_done;
    logic       pwm_out;
    logic       dir_out;
    logic [7:0] debug_signals;

    typedef struct {
        logic [7:0] ratio;
        logic       dir;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    pwm_drive #(.PRESCALE(16'd1), .DEAD_PERIODS(4'd2)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .pwm_enable    (pwm_enable),
        .pwm_update    (pwm_update),
        .pwm_ratio     (pwm_ratio),
        .pwm_direction (pwm_direction),
        .pwm_done      (pwm_done),
        .pwm_out       (pwm_out),
        .dir_out       (dir_out),
        .debug_signals (debug_signals)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_update(input logic [7:0] r, input logic d);
        @(negedge clock);
        pwm_update = 1'b1;
        pwm_ratio = r;
        pwm_direction = d;
        sb.push_back('{r, d});
        @(negedge clock);
        pwm_update = 1'b0;
    endtask

    // Waits for pwm_done, pops the scoreboard and checks the applied direction
    task automatic wait_done(input string tag, output logic [7:0] exp_ratio,
                             output int dead_cycles, output bit dead_low, output logic dir_prev);
        int n;
        exp_t e;
        n = 0;
        dead_cycles = 0;
        dead_low = 1'b1;
        dir_prev = dir_out;
        exp_ratio = 8'd0;
        while (pwm_done !== 1'b1 && n < 1100) begin
            if (debug_signals[1:0] == 2'b10) begin
                dead_cycles++;
                if (pwm_out !== 1'b0) dead_low = 1'b0;
            end
            dir_prev = dir_out;
            @(negedge clock);
            n++;
        end
        check({tag, "_done_seen"}, pwm_done, 1'b1);
        check({tag, "_sb_pending"}, (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            exp_ratio = e.ratio;
            check({tag, "_dir_out"}, dir_out, e.dir);
        end
    endtask

    // Counts high samples over the 255 cycles following a pwm_done
    task automatic measure(input string tag, input logic [7:0] exp_ratio, input int change_at,
                           input logic [7:0] new_ratio, input bit expect_done_end);
        int highs;
        bit mid_done;
        highs = 0;
        mid_done = 1'b0;
        for (int k = 1; k <= 255; k++) begin
            @(negedge clock);
            if (k == change_at) begin
                pwm_ratio = new_ratio;
                sb.push_back('{new_ratio, pwm_direction});
            end
            if (pwm_out === 1'b1) highs++;
            if (k < 255 && pwm_done !== 1'b0) mid_done = 1'b1;
        end
        check({tag, "_duty"}, highs, {24'd0, exp_ratio});
        check({tag, "_no_mid_done"}, mid_done, 1'b0);
        check({tag, "_done_at_end"}, pwm_done, expect_done_end);
    endtask

    initial begin
        logic [7:0] er;
        int         dc;
        bit         dl;
        logic       dp;
        int         n;
        int         bad_done;
        int         bad_high;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_pwm_out", pwm_out, 1'b0);
        check("rst_dir_out", dir_out, 1'b0);
        check("rst_pwm_done", pwm_done, 1'b0);
        check("rst_debug", debug_signals, 8'h00);

        reset_n = 1'b1;
        pwm_enable = 1'b1;
        @(negedge clock);
        check("enable_run", debug_signals, 8'h01);

        // Ratio 64, direction 0
        send_update(8'd64, 1'b0);
        wait_done("r64", er, dc, dl, dp);
        measure("r64", er, 0, 8'd0, 1'b0);
        check("r64_ratio_sb", er, 8'd64);

        // Ratio 0 then 255
        send_update(8'd0, 1'b0);
        wait_done("r0", er, dc, dl, dp);
        measure("r0", er, 0, 8'd0, 1'b0);
        send_update(8'd255, 1'b0);
        wait_done("r255", er, dc, dl, dp);
        measure("r255", er, 0, 8'd0, 1'b0);

        // Reversal with dead time
        send_update(8'd128, 1'b0);
        wait_done("r128", er, dc, dl, dp);
        measure("r128", er, 0, 8'd0, 1'b0);
        send_update(8'd100, 1'b1);
        wait_done("rev", er, dc, dl, dp);
        check("rev_dead_cycles", dc, 510);
        check("rev_dead_low", dl, 1'b1);
        check("rev_dir_before", dp, 1'b0);
        measure("rev", er, 0, 8'd0, 1'b0);

        // Update held high with ratio changing mid-period
        @(negedge clock);
        pwm_update = 1'b1;
        pwm_ratio = 8'd10;
        pwm_direction = 1'b1;
        sb.push_back('{8'd10, 1'b1});
        wait_done("hold10", er, dc, dl, dp);
        measure("hold10", er, 100, 8'd20, 1'b1);
        wait_done("hold20", er, dc, dl, dp);
        measure("hold20", er, 100, 8'd30, 1'b1);
        wait_done("hold30", er, dc, dl, dp);
        pwm_update = 1'b0;
        sb.push_back('{8'd30, 1'b1});
        measure("hold30", er, 0, 8'd0, 1'b1);
        wait_done("last30", er, dc, dl, dp);
        measure("last30", er, 0, 8'd0, 1'b0);

        // Enable drop mid-period
        send_update(8'd200, 1'b1);
        wait_done("r200", er, dc, dl, dp);
        repeat (50) @(negedge clock);
        check("pre_drop_high", pwm_out, 1'b1);
        pwm_enable = 1'b0;
        @(negedge clock);
        check("drop_pwm_out", pwm_out, 1'b0);
        check("drop_debug", debug_signals, 8'h08);
        check("drop_done", pwm_done, 1'b0);
        pwm_enable = 1'b1;
        bad_done = 0;
        bad_high = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clock);
            if (pwm_done !== 1'b0) bad_done++;
            if (pwm_out !== 1'b0) bad_high++;
        end
        check("reen_no_done", bad_done, 0);
        check("reen_low", bad_high, 0);
        check("reen_run", debug_signals, 8'h09);

        // Reset during DEAD
        send_update(8'd50, 1'b0);
        n = 0;
        while (debug_signals[1:0] != 2'b10 && n < 400) begin
            @(negedge clock);
            n++;
        end
        check("dead_reached", debug_signals[1:0], 2'b10);
        repeat (100) @(negedge clock);
        check("dead_dir_held", dir_out, 1'b1);
        check("dead_pwm_low", pwm_out, 1'b0);
        check("dead_sb_pending", sb.size(), 1);
        reset_n = 1'b0;
        @(negedge clock);
        check("rst_dead_pwm_out", pwm_out, 1'b0);
        check("rst_dead_dir_out", dir_out, 1'b0);
        check("rst_dead_done", pwm_done, 1'b0);
        check("rst_dead_debug", debug_signals, 8'h00);
        sb.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
